// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - CAM initiator: lookup each key byte, allocate a slot on miss, return the index
module cam_ctrl #(
  parameter int NB_MEM = 16,
  parameter int AW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_index,
  output logic          rsp_hit,
  output logic          rsp_evict,
  output logic          cam_enable,
  output logic          cam_write,
  output logic [AW-1:0] cam_addr,
  output logic [7:0]    cam_data,
  input  logic [AW-1:0] cam_out,
  output logic [AW-1:0] count
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, ALLOC, RESP} state_t;

  localparam logic [AW-1:0] LAST_SLOT  = AW'(NB_MEM - 1);
  localparam logic [AW-1:0] FIRST_SLOT = AW'(1);

  state_t        state, state_nx;
  logic [7:0]    key_q, key_nx;
  logic [AW-1:0] ptr_q, ptr_nx, count_nx;
  logic          rsp_valid_nx, rsp_hit_nx, rsp_evict_nx;
  logic [AW-1:0] rsp_index_nx;
  logic          cam_enable_nx, cam_write_nx;
  logic [AW-1:0] cam_addr_nx;
  logic [7:0]    cam_data_nx;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_q      <= '0;
      ptr_q      <= FIRST_SLOT;
      count      <= '0;
      rsp_valid  <= 1'b0;
      rsp_index  <= '0;
      rsp_hit    <= 1'b0;
      rsp_evict  <= 1'b0;
      cam_enable <= 1'b0;
      cam_write  <= 1'b0;
      cam_addr   <= '0;
      cam_data   <= '0;
    end else begin
      state      <= state_nx;
      key_q      <= key_nx;
      ptr_q      <= ptr_nx;
      count      <= count_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_index  <= rsp_index_nx;
      rsp_hit    <= rsp_hit_nx;
      rsp_evict  <= rsp_evict_nx;
      cam_enable <= cam_enable_nx;
      cam_write  <= cam_write_nx;
      cam_addr   <= cam_addr_nx;
      cam_data   <= cam_data_nx;
    end
  end

  // Outputs are registered, so each branch computes the value for the state being entered.
  always_comb begin
    state_nx      = state;
    key_nx        = key_q;
    ptr_nx        = ptr_q;
    count_nx      = count;
    rsp_valid_nx  = 1'b0;
    rsp_index_nx  = rsp_index;
    rsp_hit_nx    = rsp_hit;
    rsp_evict_nx  = rsp_evict;
    cam_enable_nx = 1'b0;
    cam_write_nx  = 1'b0;
    cam_addr_nx   = cam_addr;
    cam_data_nx   = cam_data;

    case (state)
      IDLE: begin
        if (in_valid) begin
          key_nx = in_data;
          if (in_data == 8'h00) begin
            // Key 0x00 matches every empty slot, so it never reaches the CAM.
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
            rsp_index_nx = '0;
            rsp_hit_nx   = 1'b1;
            rsp_evict_nx = 1'b0;
          end else begin
            state_nx      = LOOKUP;
            cam_enable_nx = 1'b1;
            cam_data_nx   = in_data;
          end
        end
      end
      LOOKUP: state_nx = WAIT;
      WAIT: begin
        if (cam_out != '0) begin
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
          rsp_index_nx = cam_out;
          rsp_hit_nx   = 1'b1;
          rsp_evict_nx = 1'b0;
        end else begin
          state_nx     = ALLOC;
          cam_write_nx = 1'b1;
          cam_addr_nx  = ptr_q;
          cam_data_nx  = key_q;
        end
      end
      ALLOC: begin
        state_nx     = RESP;
        rsp_valid_nx = 1'b1;
        rsp_index_nx = ptr_q;
        rsp_hit_nx   = 1'b0;
        rsp_evict_nx = (count == LAST_SLOT);
        // Slot 0 is skipped on wrap: index 0 means miss.
        ptr_nx       = (ptr_q == LAST_SLOT) ? FIRST_SLOT : ptr_q + FIRST_SLOT;
        count_nx     = (count == LAST_SLOT) ? count : count + FIRST_SLOT;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
        else           rsp_valid_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Initiator-side controller for the 8-bit-key / 5-bit-index content-addressable memory.
- Accepts a stream of key bytes over a valid/ready handshake.
- For each key, issues a CAM lookup. On a miss, allocates the next slot and issues a CAM write. Returns the slot index, with hit/evict flags, over a second valid/ready handshake.
- Sits between the byte-stream front end (dictionary encoder path) and the CAM instance.

Parameters:
- NB_MEM, 16, number of CAM slots; must match the CAM instance, 2..32.
- AW, 5, index/address width; must satisfy 2^AW >= NB_MEM.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  key byte present.
- in_ready  output  1  controller can accept a key (high only in IDLE).
- in_data  input  8  key byte.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_index  output  AW  slot index for the key.
- rsp_hit  output  1  1 = key already present; 0 = newly allocated.
- rsp_evict  output  1  1 = allocation overwrote an occupied slot.
- cam_enable  output  1  CAM lookup strobe.
- cam_write  output  1  CAM write strobe.
- cam_addr  output  AW  CAM write slot.
- cam_data  output  8  CAM key.
- cam_out  input  AW  CAM registered match index; 0 = miss; valid one cycle after the strobe.
- count  output  AW  occupied slots, 0..NB_MEM-1.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - in_ready=1.
  - rsp_valid, rsp_index, rsp_hit and rsp_evict all go to 0.
  - cam_enable, cam_write, cam_addr and cam_data all go to 0.
  - count=0; allocation pointer ptr=1; captured key reg=0.
  - Reset mid-transaction drops the in-flight key and its response.
- Slot 0 is reserved and never allocated, because index 0 encodes a miss.
- Key 0x00 is reserved. It matches the reset contents of every slot. It is answered without any CAM access.
- FSM states are IDLE, LOOKUP, WAIT, ALLOC and RESP. One cycle per state except RESP.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_data into key reg.
  - If key is 0x00, go to RESP with index 0, hit=1, evict=0.
  - Otherwise go to LOOKUP.
- LOOKUP: cam_enable=1, cam_data=key, cam_write=0. Then go to WAIT.
- WAIT:
  - Strobes are low; sample cam_out.
  - If cam_out is nonzero, go to RESP with index=cam_out, hit=1, evict=0.
  - If cam_out is 0, go to ALLOC.
- ALLOC:
  - cam_write=1, cam_enable=0, cam_addr=ptr, cam_data=key.
  - Response fields: index=ptr, hit=0, evict=(count==NB_MEM-1).
  - ptr increments, wrapping from NB_MEM-1 to 1.
  - count increments, saturating at NB_MEM-1.
  - Then go to RESP.
  - cam_write is issued only in the cycle directly after a miss, so the CAM's internally registered result is 0 and the write commits.
- RESP:
  - rsp_valid=1; rsp_index, rsp_hit and rsp_evict are held stable.
  - When rsp_ready is high, the response completes and the state returns to IDLE.
  - rsp_ready held low stalls indefinitely; no key is accepted while stalled.
- Latency from the accept edge to rsp_valid:
  - Hit: 3 cycles.
  - Miss: 4 cycles.
  - Key 0x00: 1 cycle.
- Throughput: one key per 4 cycles (hit) or 5 cycles (miss) with rsp_ready held high.
- cam_enable and cam_write are never high in the same cycle.
- Strobes are single-cycle pulses, registered outputs.
- Full-table policy is round-robin overwrite of the oldest slot. The evicted key is no longer findable afterwards.

Test Plan:
1. Reset, then keys 0x41, 0x42, 0x41 with rsp_ready=1 -> responses (1,hit0), (2,hit0), (1,hit1); count=2; two cam_write pulses, with cam_addr 1 then 2.
2. Key 0x00 -> rsp_index=0, rsp_hit=1, rsp_valid one cycle after accept; cam_enable and cam_write never pulse.
3. Fifteen distinct keys 0x01..0x0F, then 0x10 -> indices 1..15 with evict=0, count=15; 0x10 gets index 1 with evict=1; a following key 0x01 misses and is allocated index 2 with evict=1.
4. Key 0x55 with rsp_ready=0 for 10 cycles -> rsp_valid and fields stable, in_ready=0 throughout; after rsp_ready=1 for one cycle, in_ready=1 the next cycle.
5. Assert rst_n low during the ALLOC cycle of key 0x77 -> all outputs at reset values immediately; count=0 and ptr=1 after release; no response is emitted.
6. Back-to-back in_valid with the hit key 0x41 and rsp_ready=1 -> check cycle timing: cam_enable at accept+1, rsp_valid at accept+3, next accept at accept+4.
